unified_mem_responder: RTL and testbench
========================================

UNIFIED_MEM_RESPONDER -- requirements
Module: unified_mem_responder

Interface
REQ-001 Parameter ADDR_W, default 8, byte-address width; memory depth is 2^ADDR_W bytes.
REQ-002 Parameter WAIT_CYCLES, default 2, number of extra wait cycles per access when MEM_WAIT_STATE_EN is defined.
REQ-003 One clock; reset is synchronous and active-high.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 i_req  in  1  instruction-fetch request, held until i_ack.
REQ-007 i_addr  in  ADDR_W  fetch byte address; bits [1:0] ignored.
REQ-008 i_ack  out  1  one-cycle pulse; i_rdata valid in the same cycle.
REQ-009 i_rdata  out  32  fetched word, little-endian.
REQ-010 d_req  in  1  data request, held with all d_* inputs stable until d_ack.
REQ-011 d_we  in  1  1 = store, 0 = load.
REQ-012 d_addr  in  ADDR_W  data byte address.
REQ-013 d_func3  in  3  RV32 load/store funct3.
REQ-014 d_wdata  in  32  store data; low byte/half used for SB/SH.
REQ-015 d_ack  out  1  one-cycle pulse completing a data access.
REQ-016 d_rdata  out  32  load result, extended per d_func3; valid while d_ack=1.
REQ-017 d_err  out  1  valid with d_ack; 1 = access rejected.

Function
REQ-018 The FSM SHALL have states IDLE, WAIT, RESP; IDLE->WAIT on a grant with wait states enabled, IDLE->RESP on a grant otherwise, WAIT->RESP when wait counter reaches WAIT_CYCLES-1, RESP->IDLE unconditionally.
REQ-019 Arbitration in IDLE: data has priority over fetch, except that a pending fetch wins the first arbitration after a data ack (one-slot fairness).
REQ-020 Request inputs SHALL be registered at grant; later changes to them before ack SHALL NOT affect the transaction.
REQ-021 Ack SHALL be asserted only in RESP, for exactly one cycle, on the granted port only.
REQ-022 Latency from grant cycle to ack: 1 cycle without wait states, 1+WAIT_CYCLES with.
REQ-023 A requester still asserting req in the cycle after its ack SHALL be treated as a new request.
REQ-024 Loads: 000 LB sign-extend, 001 LH sign-extend, 010 LW, 100 LBU zero-extend, 101 LHU zero-extend; little-endian byte order.
REQ-025 Stores: 000 SB, 001 SH, 010 SW; only the addressed bytes SHALL change.
REQ-026 A store SHALL commit to the array on the clock edge ending the RESP cycle, never earlier.
REQ-027 Misaligned (half with addr[0]=1, word with addr[1:0]!=0) or reserved funct3 (011, 110, 111; 100/101 with d_we=1) SHALL give d_ack=1, d_err=1, d_rdata=0, and no write.
REQ-028 Fetch SHALL read the aligned word at {i_addr[ADDR_W-1:2],2'b00} and never raise an error.
REQ-029 i_rdata/d_rdata SHALL be 0 in every cycle their ack is low.
REQ-030 A fetch granted in the cycle after a store acks SHALL see the stored data.

Reset
REQ-031 When rst=1 at a clock edge: state=IDLE, wait counter=0, fairness flag=0, i_ack=d_ack=d_err=0, i_rdata=d_rdata=0.
REQ-032 Reset during WAIT or RESP SHALL abort the transaction with no ack and no write.
REQ-033 Memory array contents SHALL NOT be cleared by reset.

Configuration
REQ-034 Macro MEM_WAIT_STATE_EN: defined -> WAIT state and counter present, latency 1+WAIT_CYCLES (WAIT_CYCLES=0 behaves as undefined); undefined -> WAIT state and counter absent, latency 1, WAIT_CYCLES ignored.

Verification
REQ-035 SW 0xDEADBEEF @0x10, then LW @0x10 -> d_rdata=0xDEADBEEF, d_err=0; LB @0x13 -> 0xFFFFFFDE; LBU @0x13 -> 0x000000DE; LH @0x12 -> 0xFFFFDEAD.
REQ-036 SB 0x55 @0x11 over 0xDEADBEEF, then LW @0x10 -> 0xDEAD55EF.
REQ-037 i_req and d_req asserted in the same cycle, both held continuously -> grant order data, fetch, data, fetch; no ack overlap.
REQ-038 LW @0x22 or SH @0x05 -> d_ack=1, d_err=1, d_rdata=0; a following LW of the target word returns its previous value.
REQ-039 With MEM_WAIT_STATE_EN, WAIT_CYCLES=2: ack exactly 3 cycles after grant; rst asserted in WAIT during SW -> no ack, memory unchanged, outputs 0.
REQ-040 i_addr=0x13 after SW 0x01234567 @0x10 -> i_rdata=0x01234567 in the ack cycle.

Source files
------------

// File: rtl/unified_mem_responder.sv
// unified_mem_responder: byte memory shared by a fetch port and a data port; MEM_WAIT_STATE_EN adds WAIT_CYCLES wait states
module unified_mem_responder #(
  parameter int ADDR_W = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ack,
  output logic [31:0]       i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [2:0]        d_func3,
  input  logic [31:0]       d_wdata,
  output logic              d_ack,
  output logic [31:0]       d_rdata,
  output logic              d_err
);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state, state_n;
  logic [7:0] mem [2**ADDR_W];
  logic fair, gd, rwe, grant, pick_d, last, err, resp;
  logic [ADDR_W-1:0] ra;
  logic [2:0] rf3;
  logic [31:0] rwd, word, sh, ld, wlane;
  logic [3:0] mask;
  assign grant = i_req | d_req;
  assign pick_d = d_req & ~(fair & i_req);
`ifdef MEM_WAIT_STATE_EN
  localparam bit use_wait = WAIT_CYCLES > 0;
  localparam int cw = WAIT_CYCLES > 1 ? $clog2(WAIT_CYCLES) : 1;
  logic [cw-1:0] cnt;
  assign last = int'(cnt) == WAIT_CYCLES - 1;
  // wait counter only advances while in WAIT
  always_ff @(posedge clk) cnt <= (rst || state != WAIT) ? '0 : cnt + 1'b1;
`else
  localparam bit use_wait = 1'b0;
  assign last = 1'b1;
`endif
  // state register
  always_ff @(posedge clk) state <= rst ? IDLE : state_n;
  // next state: a grant leaves IDLE, the counter ends WAIT, RESP always returns
  always_comb
    state_n = state == IDLE ? (grant ? (use_wait ? WAIT : RESP) : IDLE)
            : state == WAIT ? (last ? RESP : WAIT) : IDLE;
  // latch the winning request; a data ack hands the next contested slot to fetch
  always_ff @(posedge clk)
    if (rst) fair <= 1'b0;
    else if (state == IDLE && grant) begin
      fair <= 1'b0;
      gd <= pick_d;
      ra <= pick_d ? d_addr : i_addr;
      rwe <= d_we;
      rf3 <= d_func3;
      rwd <= d_wdata;
    end else if (resp && gd) fair <= 1'b1;
  assign err = rf3 == 3'b011 || rf3[2:1] == 2'b11 || (rwe && rf3[2])
             || (rf3[1:0] == 2'b01 && ra[0]) || (rf3[1:0] == 2'b10 && ra[1:0] != 2'b00);
  assign word = {mem[{ra[ADDR_W-1:2], 2'd3}], mem[{ra[ADDR_W-1:2], 2'd2}],
                 mem[{ra[ADDR_W-1:2], 2'd1}], mem[{ra[ADDR_W-1:2], 2'd0}]};
  assign sh = word >> {ra[1:0], 3'b000};
  assign ld = rf3[1:0] == 2'b00 ? {{24{~rf3[2] & sh[7]}}, sh[7:0]}
            : rf3[1:0] == 2'b01 ? {{16{~rf3[2] & sh[15]}}, sh[15:0]} : sh;
  assign wlane = rf3[1:0] == 2'b00 ? {4{rwd[7:0]}} : rf3[1:0] == 2'b01 ? {2{rwd[15:0]}} : rwd;
  assign mask = rf3[1:0] == 2'b00 ? 4'b0001 << ra[1:0] : rf3[1:0] == 2'b01 ? 4'b0011 << ra[1:0] : 4'b1111;
  // acks and read data only appear in RESP, on the granted port, and vanish under reset
  always_comb begin
    resp = state == RESP && !rst;
    i_ack = resp && !gd;
    d_ack = resp && gd;
    d_err = d_ack && err;
    i_rdata = i_ack ? word : '0;
    d_rdata = d_ack && !err && !rwe ? ld : '0;
  end
  // stores commit on the edge closing RESP; the array is never reset
  always_ff @(posedge clk)
    if (d_ack && rwe && !err)
      for (int k = 0; k < 4; k++)
        if (mask[k]) mem[{ra[ADDR_W-1:2], k[1:0]}] <= wlane[8*k +: 8];
endmodule

// File: tb/tb_unified_mem_responder.sv
// tb_unified_mem_responder: random and directed checks against a byte-array reference model
module tb_unified_mem_responder;
  localparam int WC = 2;
`ifdef MEM_WAIT_STATE_EN
  localparam int LAT = WC > 0 ? 1 + WC : 1;
`else
  localparam int LAT = 1;
`endif
  logic clk = 0, rst = 1;
  logic i_req = 0, i_ack, d_req = 0, d_we = 0, d_ack, d_err;
  logic [7:0] i_addr = 0, d_addr = 0;
  logic [2:0] d_func3 = 0;
  logic [31:0] d_wdata = 0, i_rdata, d_rdata;
  int n_cmp = 0, n_bad = 0;
  logic [7:0] mm [256];
  bit last_data = 0, last_err;
  logic [31:0] last_rd, last_ir, old;
  int k, cyc;
  logic [3:0] ord;

  unified_mem_responder #(.ADDR_W(8), .WAIT_CYCLES(WC)) dut (
    .clk(clk), .rst(rst), .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_func3(d_func3), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mword(input logic [7:0] a);
    int b = {24'd0, a[7:2], 2'b00};
    return {mm[b+3], mm[b+2], mm[b+1], mm[b]};
  endfunction

  function automatic void model_data(input bit we, input logic [2:0] f, input logic [7:0] a,
                                     input logic [31:0] wd, output bit e, output logic [31:0] r);
    int sz = f[1:0] == 0 ? 1 : f[1:0] == 1 ? 2 : 4;
    e = f == 3 || f >= 6 || (we && f >= 4) || (int'(a) % sz != 0);
    r = 0;
    if (e) return;
    for (int i = 0; i < sz; i++)
      if (we) mm[int'(a) + i] = wd[8*i +: 8];
      else r[8*i +: 8] = mm[int'(a) + i];
    if (we) r = 0;
    else if (f < 4 && sz < 4 && r[8*sz-1]) r = r | (32'hFFFFFFFF << (8*sz));
  endfunction

  task automatic setd(input bit we, input logic [2:0] f, input logic [7:0] a, input logic [31:0] wd);
    d_we = we; d_func3 = f; d_addr = a; d_wdata = wd;
  endtask

  task automatic run(input bit fi, input bit fd);
    bit fp = fi, dp = fd, e, exp_d;
    int c = 0, nack = 0;
    logic [31:0] r;
    @(negedge clk);
    exp_d = fi && fd ? !last_data : fd;
    i_req = fi; d_req = fd;
    while ((fp || dp) && c < 40) begin
      @(negedge clk);
      c++;
      if (!i_ack) chk("i_rdata_idle", i_rdata, 0);
      if (!d_ack) chk("d_rdata_idle", d_rdata, 0);
      if (i_ack || d_ack) begin
        chk("ack_port", {30'd0, i_ack, d_ack}, exp_d ? 32'd1 : 32'd2);
        chk("latency", c, nack == 0 ? LAT : 2*LAT + 1);
        if (d_ack) begin
          model_data(d_we, d_func3, d_addr, d_wdata, e, r);
          chk("d_err", {31'd0, d_err}, {31'd0, e});
          chk("d_rdata", d_rdata, r);
          last_rd = d_rdata; last_err = d_err;
          dp = 0; d_req = 0; last_data = 1;
        end else begin
          chk("i_rdata", i_rdata, mword(i_addr));
          last_ir = i_rdata;
          fp = 0; i_req = 0; last_data = 0;
        end
        nack++;
        exp_d = !exp_d;
      end
    end
    if (fp || dp) begin
      chk("timeout", 1, 0);
      i_req = 0; d_req = 0;
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_i_ack", {31'd0, i_ack}, 0);
    chk("rst_d_ack", {31'd0, d_ack}, 0);
    chk("rst_d_err", {31'd0, d_err}, 0);
    chk("rst_rdata", i_rdata | d_rdata, 0);
    rst = 0;
    // both ports held continuously: data, fetch, data, fetch
    setd(0, 3'd2, 8'h10, 0);
    @(negedge clk);
    i_req = 1; d_req = 1; k = 0; cyc = 0; ord = 0;
    while (k < 4 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (i_ack || d_ack) begin
        ord[k] = d_ack;
        chk("no_overlap", {31'd0, i_ack & d_ack}, 0);
        k++;
      end
    end
    i_req = 0; d_req = 0;
    chk("grant_order", {28'd0, ord}, 32'h5);
    chk("order_acks", k, 4);
    last_data = 0;
    for (int a = 0; a < 256; a += 4) begin
      setd(1, 3'd2, a[7:0], $urandom);
      run(0, 1);
    end
    // directed byte-lane and extension cases
    setd(1, 3'd2, 8'h10, 32'hDEADBEEF); run(0, 1);
    setd(0, 3'd2, 8'h10, 0); run(0, 1);
    chk("lw", last_rd, 32'hDEADBEEF); chk("lw_err", {31'd0, last_err}, 0);
    setd(0, 3'd0, 8'h13, 0); run(0, 1); chk("lb", last_rd, 32'hFFFFFFDE);
    setd(0, 3'd4, 8'h13, 0); run(0, 1); chk("lbu", last_rd, 32'h000000DE);
    setd(0, 3'd1, 8'h12, 0); run(0, 1); chk("lh", last_rd, 32'hFFFFDEAD);
    setd(1, 3'd0, 8'h11, 32'hAB12CD55); run(0, 1);
    setd(0, 3'd2, 8'h10, 0); run(0, 1); chk("sb_merge", last_rd, 32'hDEAD55EF);
    old = mword(8'h20);
    setd(0, 3'd2, 8'h22, 0); run(0, 1);
    chk("mis_lw_err", {31'd0, last_err}, 1); chk("mis_lw_rd", last_rd, 0);
    setd(0, 3'd2, 8'h20, 0); run(0, 1); chk("mis_lw_keep", last_rd, old);
    old = mword(8'h04);
    setd(1, 3'd1, 8'h05, 32'hFFFFFFFF); run(0, 1);
    chk("mis_sh_err", {31'd0, last_err}, 1);
    setd(0, 3'd2, 8'h04, 0); run(0, 1); chk("mis_sh_keep", last_rd, old);
    setd(1, 3'd4, 8'h08, 0); run(0, 1); chk("rsvd_store_err", {31'd0, last_err}, 1);
    i_addr = 8'h00; run(1, 0);
    setd(1, 3'd2, 8'h10, 32'h01234567); i_addr = 8'h13; run(1, 1);
    chk("fetch_after_store", last_ir, 32'h01234567);
    // reset mid-transaction aborts a store
    old = mword(8'h40);
    setd(1, 3'd2, 8'h40, 32'h12345678);
    @(negedge clk);
    d_req = 1;
    @(posedge clk);
    #1 rst = 1;
    @(negedge clk);
    chk("abort_d_ack", {31'd0, d_ack}, 0);
    chk("abort_rdata", d_rdata | i_rdata, 0);
    d_req = 0;
    @(posedge clk);
    #1 rst = 0;
    last_data = 0;
    setd(0, 3'd2, 8'h40, 0); run(0, 1); chk("abort_nowrite", last_rd, old);
    for (int n = 0; n < 300; n++) begin
      i_addr = $urandom;
      setd($urandom_range(0, 1) == 1, $urandom_range(0, 7), $urandom, $urandom);
      if ($urandom_range(0, 3) != 0) d_addr[1:0] = 2'b00;
      case ($urandom_range(0, 2))
        0: run(1, 0);
        1: run(0, 1);
        default: run(1, 1);
      endcase
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
